seg7_mux_driver: RTL and testbench

- Parametrised multiplexed seven-segment driver for N_DIGITS digits.
- Converts a binary value to BCD with a sequential double-dabble FSM, started by a load handshake; optionally handles signed values.
- Time-multiplexes the digit anodes, with optional leading-zero blanking, minus sign and overflow indication.
- Sits between datapath/switch logic and the board display pins; supersedes the fixed 9-bit, 4-digit divider/BCD/decoder chain.

---
 rtl/seg7_mux_driver.sv | 251 +++++++++++++++++++++++++
 tb/tb_seg7_mux_driver.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver
//   Multiplexed seven-segment driver for N_DIGITS digits. A load request
//   starts a sequential double-dabble conversion of 'value' (optionally
//   two's complement) into BCD. When the conversion finishes, the result is
//   copied into the display registers. A free-running refresh counter scans
//   the digit anodes. The scan supports leading-zero blanking, a minus sign
//   and an all-minus overflow indication.
//
// Handshake: a request is accepted on a rising edge where load=1 and busy=0.
//   busy stays high from the edge after acceptance until the edge after the
//   done pulse. Requests made while busy=1 are dropped and not queued.
//   done is high for exactly one cycle. The new result, neg and ovf are
//   already in the display registers during that cycle.
//
// Ports:
//   CLK_50  in   system clock, rising edge
//   RST_N   in   asynchronous active-low reset
//   value   in   [IN_WIDTH-1:0] binary value, sampled on an accepted load
//   load    in   conversion request
//   busy    out  conversion in progress
//   done    out  one-cycle pulse, new result on display
//   ovf     out  last accepted value did not fit the display
//   SSeg    out  [0:6] segments a..g, active-low (SSeg[0]=a)
//   an      out  [N_DIGITS-1:0] active-low one-hot anodes, an[0] = LSD
module seg7_mux_driver #(
  parameter int N_DIGITS    = 4,
  parameter int IN_WIDTH    = 9,
  parameter bit SIGNED      = 1'b0,
  parameter bit BLANK_LZ    = 1'b1,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                CLK_50,
  input  logic                RST_N,
  input  logic [IN_WIDTH-1:0] value,
  input  logic                load,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic [0:6]          SSeg,
  output logic [N_DIGITS-1:0] an
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int MP_W  = IDX_W + 1;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_MINUS = 7'b1111110;
  localparam logic [0:6] SEG_ZERO  = 7'b0000001;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 0; i < n; i++) r = r * 32'd10;
    return r;
  endfunction

  // A negative result gives up one digit position to the minus sign.
  localparam logic [31:0] LIMIT_POS = pow10(N_DIGITS) - 32'd1;
  localparam logic [31:0] LIMIT_NEG = pow10(N_DIGITS - 1) - 32'd1;

  function automatic logic [0:6] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Conversion working registers
  logic [IN_WIDTH-1:0] mag;
  logic [BCD_W-1:0]    bcd;
  logic [CNT_W-1:0]    bit_cnt;
  logic                neg_work;
  logic                ovf_work;

  // Display registers
  logic [BCD_W-1:0]    disp_bcd;
  logic                disp_neg;

  // Refresh scan
  logic [REF_W-1:0]    ref_cnt;
  logic [IDX_W-1:0]    digit_idx;

  // Capture-side arithmetic
  logic                neg_in;
  logic [IN_WIDTH-1:0] mag_in;
  logic [31:0]         mag_ext;
  logic                ovf_in;

  assign neg_in  = SIGNED ? value[IN_WIDTH-1] : 1'b0;
  // Negation in IN_WIDTH bits: the most negative value maps to its correct
  // unsigned magnitude (e.g. 9'h100 -> 256).
  assign mag_in  = neg_in ? -value : value;
  assign mag_ext = {{(32-IN_WIDTH){1'b0}}, mag_in};
  assign ovf_in  = mag_ext > (neg_in ? LIMIT_NEG : LIMIT_POS);

  // Double-dabble step: correct each nibble, then shift {bcd, mag} left.
  logic [BCD_W-1:0]    bcd_adj;
  logic [BCD_W-1:0]    bcd_shift;
  logic                bcd_spill;
  logic [IN_WIDTH-1:0] mag_shift;

  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
    {bcd_spill, bcd_shift} = {bcd_adj, mag[IN_WIDTH-1]};
    mag_shift = {mag[IN_WIDTH-2:0], 1'b0};
  end

  // FSM next state and status outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (bit_cnt == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Conversion datapath. The display registers are loaded on the final
  // shift edge, so they hold the new result during the done cycle.
  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      mag      <= '0;
      bcd      <= '0;
      bit_cnt  <= '0;
      neg_work <= 1'b0;
      ovf_work <= 1'b0;
      disp_bcd <= '0;
      disp_neg <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load) begin
            mag      <= mag_in;
            bcd      <= '0;
            bit_cnt  <= CNT_W'(IN_WIDTH);
            neg_work <= neg_in;
            ovf_work <= ovf_in;
          end
        end
        S_SHIFT: begin
          mag     <= mag_shift;
          bcd     <= bcd_shift;
          bit_cnt <= bit_cnt - CNT_W'(1);
          // A carry out of the top nibble also means the value did not
          // fit. ovf_in already covers this case, so the OR only keeps the
          // two indications consistent.
          if (bit_cnt == CNT_W'(1)) begin
            disp_bcd <= bcd_shift;
            disp_neg <= neg_work;
            ovf      <= ovf_work | bcd_spill;
          end else begin
            ovf_work <= ovf_work | bcd_spill;
          end
        end
        default: ;
      endcase
    end
  end

  // Refresh counter and digit index, free running
  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      ref_cnt   <= '0;
      digit_idx <= '0;
    end else if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
      ref_cnt <= '0;
      if (digit_idx == IDX_W'(N_DIGITS - 1)) digit_idx <= '0;
      else                                   digit_idx <= digit_idx + IDX_W'(1);
    end else begin
      ref_cnt <= ref_cnt + REF_W'(1);
    end
  end

  // Digit content for the current scan index
  logic [IDX_W-1:0] hi_digit;
  logic [MP_W-1:0]  minus_pos;
  logic [3:0]       cur_nib;
  logic [0:6]       seg_d;
  logic [N_DIGITS-1:0] an_d;

  always_comb begin
    hi_digit = '0;
    cur_nib  = '0;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (disp_bcd[4*d +: 4] != 4'd0) hi_digit = IDX_W'(d);
      if (IDX_W'(d) == digit_idx)     cur_nib  = disp_bcd[4*d +: 4];
    end
    // hi_digit is 0 for a zero magnitude, which puts the minus at index 1.
    minus_pos = BLANK_LZ ? ({1'b0, hi_digit} + MP_W'(1)) : MP_W'(N_DIGITS - 1);

    if (ovf)                                          seg_d = SEG_MINUS;
    else if (disp_neg && {1'b0, digit_idx} == minus_pos) seg_d = SEG_MINUS;
    else if (BLANK_LZ && digit_idx > hi_digit)        seg_d = SEG_BLANK;
    else                                              seg_d = seg_decode(cur_nib);

    an_d = ~(N_DIGITS'(1) << digit_idx);
  end

  // Segments and anodes share one register stage so they switch together.
  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      SSeg <= SEG_ZERO;
      an   <= {{(N_DIGITS-1){1'b1}}, 1'b0};
    end else begin
      SSeg <= seg_d;
      an   <= an_d;
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
module tb_seg7_mux_driver;

  localparam int RD = 4;

  localparam logic [0:6] S0 = 7'b0000001;
  localparam logic [0:6] S1 = 7'b1001111;
  localparam logic [0:6] S2 = 7'b0010010;
  localparam logic [0:6] S3 = 7'b0000110;
  localparam logic [0:6] S4 = 7'b1001100;
  localparam logic [0:6] S5 = 7'b0100100;
  localparam logic [0:6] S6 = 7'b0100000;
  localparam logic [0:6] S7 = 7'b0001111;
  localparam logic [0:6] BL = 7'b1111111;
  localparam logic [0:6] MI = 7'b1111110;

  logic [0:6] seg_tab [10];

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       load  = 1'b0;
  logic [8:0] value = 9'd0;

  always #5 clk = ~clk;

  // u0: defaults (4 digits, unsigned, blanking)
  // u1: 2 digits, unsigned
  // u2: signed, blanking
  // u3: signed, no blanking
  logic busy0, done0, ovf0; logic [0:6] seg0; logic [3:0] an0;
  logic busy1, done1, ovf1; logic [0:6] seg1; logic [1:0] an1;
  logic busy2, done2, ovf2; logic [0:6] seg2; logic [3:0] an2;
  logic busy3, done3, ovf3; logic [0:6] seg3; logic [3:0] an3;

  seg7_mux_driver #(.N_DIGITS(4), .IN_WIDTH(9), .SIGNED(1'b0), .BLANK_LZ(1'b1), .REFRESH_DIV(RD)) u0 (
    .CLK_50(clk), .RST_N(rst_n), .value(value), .load(load),
    .busy(busy0), .done(done0), .ovf(ovf0), .SSeg(seg0), .an(an0));
  seg7_mux_driver #(.N_DIGITS(2), .IN_WIDTH(9), .SIGNED(1'b0), .BLANK_LZ(1'b1), .REFRESH_DIV(RD)) u1 (
    .CLK_50(clk), .RST_N(rst_n), .value(value), .load(load),
    .busy(busy1), .done(done1), .ovf(ovf1), .SSeg(seg1), .an(an1));
  seg7_mux_driver #(.N_DIGITS(4), .IN_WIDTH(9), .SIGNED(1'b1), .BLANK_LZ(1'b1), .REFRESH_DIV(RD)) u2 (
    .CLK_50(clk), .RST_N(rst_n), .value(value), .load(load),
    .busy(busy2), .done(done2), .ovf(ovf2), .SSeg(seg2), .an(an2));
  seg7_mux_driver #(.N_DIGITS(4), .IN_WIDTH(9), .SIGNED(1'b1), .BLANK_LZ(1'b0), .REFRESH_DIV(RD)) u3 (
    .CLK_50(clk), .RST_N(rst_n), .value(value), .load(load),
    .busy(busy3), .done(done3), .ovf(ovf3), .SSeg(seg3), .an(an3));

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] cur_an(input int inst);
    case (inst)
      0:       return {4'hf, an0};
      1:       return {6'h3f, an1};
      2:       return {4'hf, an2};
      default: return {4'hf, an3};
    endcase
  endfunction

  function automatic logic [0:6] cur_seg(input int inst);
    case (inst)
      0:       return seg0;
      1:       return seg1;
      2:       return seg2;
      default: return seg3;
    endcase
  endfunction

  function automatic logic cur_ovf(input int inst);
    case (inst)
      0:       return ovf0;
      1:       return ovf1;
      2:       return ovf2;
      default: return ovf3;
    endcase
  endfunction

  // Reference model computed with decimal arithmetic on the whole value.
  function automatic logic model_ovf(input int n, input bit sgn, input int v);
    int p, mag, lim;
    bit neg;
    neg = sgn && (v >= 256);
    mag = neg ? 512 - v : v;
    p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    lim = neg ? p / 10 - 1 : p - 1;
    return mag > lim;
  endfunction

  function automatic logic [0:6] model_seg(input int n, input bit sgn, input bit blz,
                                            input int v, input int idx);
    int mag, hi, dig, p;
    bit neg;
    neg = sgn && (v >= 256);
    mag = neg ? 512 - v : v;
    if (model_ovf(n, sgn, v)) return MI;
    hi = 0;
    p  = 1;
    dig = 0;
    for (int k = 0; k < n; k++) begin
      if (((mag / p) % 10) != 0) hi = k;
      if (k == idx) dig = (mag / p) % 10;
      p = p * 10;
    end
    if (neg && idx == (blz ? hi + 1 : n - 1)) return MI;
    if (blz && idx > hi) return BL;
    return seg_tab[dig];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_an(input int inst, input int idx, output bit seen);
    logic [7:0] want;
    want = ~(8'd1 << idx);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (cur_an(inst) == want) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_digit(input int inst, input int idx, input logic [0:6] exp, input string tag);
    bit seen;
    wait_an(inst, idx, seen);
    chk({tag, "_an_seen"}, 32'(seen), 32'd1);
    chk(tag, 32'(cur_seg(inst)), 32'(exp));
  endtask

  // Issues a one-cycle load, optionally a second load at cycle extra_at,
  // and watches u0 busy/done for 20 cycles.
  task automatic convert(input logic [8:0] v, input int extra_at, input logic [8:0] extra_v,
                         output int busy_n, output int done_n, output int done_at);
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    value = v;
    load  = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) load = 1'b0;
      if (extra_at > 0 && i == extra_at) begin
        value = extra_v;
        load  = 1'b1;
      end else if (extra_at > 0 && i == extra_at + 1) begin
        load = 1'b0;
      end
      if (busy0) busy_n++;
      if (done0) begin
        done_n++;
        done_at = i;
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int bn, dn, da, n;
    logic [3:0] prev;
    logic [3:0] exp_an [4];
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_ovf",  32'(ovf0),  32'd0);
    chk("rst_an",   32'(an0),   32'b1110);
    chk("rst_seg",  32'(seg0),  32'(S0));
    rst_n = 1'b1;

    // Anode scan order and period
    prev = an0;
    n = 0;
    while (an0 == prev && n < 20) begin @(negedge clk); n++; end
    chk("scan_first", 32'(an0), 32'b1101);
    for (int j = 2; j <= 4; j++) begin
      prev = an0;
      n = 0;
      while (an0 == prev && n < 20) begin @(negedge clk); n++; end
      chk("scan_period", 32'(n), 32'd4);
      chk("scan_seq", 32'(an0), 32'(exp_an[j % 4]));
    end
    check_digit(0, 0, S0, "idle_d0");
    check_digit(0, 1, BL, "idle_d1");
    check_digit(0, 2, BL, "idle_d2");
    check_digit(0, 3, BL, "idle_d3");
    chk("idle_busy", 32'(busy0), 32'd0);
    chk("idle_done", 32'(done0), 32'd0);

    // 345: latency, unsigned blanking, N=2 overflow, signed as -167
    convert(9'd345, 0, 9'd0, bn, dn, da);
    chk("c345_busy_cycles", 32'(bn), 32'd10);
    chk("c345_done_count",  32'(dn), 32'd1);
    chk("c345_done_at",     32'(da), 32'd10);
    chk("c345_ovf0", 32'(ovf0), 32'd0);
    check_digit(0, 0, S5, "c345_u0_d0");
    check_digit(0, 1, S4, "c345_u0_d1");
    check_digit(0, 2, S3, "c345_u0_d2");
    check_digit(0, 3, BL, "c345_u0_d3");
    chk("c345_ovf1", 32'(ovf1), 32'd1);
    check_digit(1, 0, MI, "c345_u1_d0");
    check_digit(1, 1, MI, "c345_u1_d1");
    check_digit(2, 0, S7, "c345_u2_d0");
    check_digit(2, 1, S6, "c345_u2_d1");
    check_digit(2, 2, S1, "c345_u2_d2");
    check_digit(2, 3, MI, "c345_u2_d3");

    // 511: N=2 overflow, signed -1
    convert(9'd511, 0, 9'd0, bn, dn, da);
    chk("c511_ovf1", 32'(ovf1), 32'd1);
    check_digit(1, 0, MI, "c511_u1_d0");
    check_digit(1, 1, MI, "c511_u1_d1");
    check_digit(0, 2, S5, "c511_u0_d2");
    check_digit(2, 0, S1, "c511_u2_d0");
    check_digit(2, 1, MI, "c511_u2_d1");
    check_digit(2, 2, BL, "c511_u2_d2");

    // 42: overflow clears; no-blank shows leading zeros
    convert(9'd42, 0, 9'd0, bn, dn, da);
    chk("c42_ovf1", 32'(ovf1), 32'd0);
    check_digit(1, 0, S2, "c42_u1_d0");
    check_digit(1, 1, S4, "c42_u1_d1");
    check_digit(3, 3, S0, "c42_u3_d3");
    check_digit(3, 1, S4, "c42_u3_d1");

    // -10
    convert(9'h1F6, 0, 9'd0, bn, dn, da);
    chk("cm10_ovf2", 32'(ovf2), 32'd0);
    check_digit(2, 0, S0, "cm10_u2_d0");
    check_digit(2, 1, S1, "cm10_u2_d1");
    check_digit(2, 2, MI, "cm10_u2_d2");
    check_digit(2, 3, BL, "cm10_u2_d3");
    check_digit(3, 0, S0, "cm10_u3_d0");
    check_digit(3, 1, S1, "cm10_u3_d1");
    check_digit(3, 2, S0, "cm10_u3_d2");
    check_digit(3, 3, MI, "cm10_u3_d3");

    // -256, the most negative value
    convert(9'h100, 0, 9'd0, bn, dn, da);
    check_digit(2, 0, S6, "cm256_u2_d0");
    check_digit(2, 1, S5, "cm256_u2_d1");
    check_digit(2, 2, S2, "cm256_u2_d2");
    check_digit(2, 3, MI, "cm256_u2_d3");
    check_digit(3, 3, MI, "cm256_u3_d3");

    // Load during busy is ignored: result stays 42, single done at 10
    convert(9'd42, 3, 9'd345, bn, dn, da);
    chk("ign_busy_cycles", 32'(bn), 32'd10);
    chk("ign_done_count",  32'(dn), 32'd1);
    chk("ign_done_at",     32'(da), 32'd10);
    chk("ign_ovf1", 32'(ovf1), 32'd0);
    check_digit(1, 0, S2, "ign_u1_d0");
    check_digit(1, 1, S4, "ign_u1_d1");
    check_digit(0, 2, BL, "ign_u0_d2");

    // Reset mid-conversion (u1 shows overflow beforehand)
    convert(9'd511, 0, 9'd0, bn, dn, da);
    chk("pre_rst_ovf1", 32'(ovf1), 32'd1);
    value = 9'd345;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before_rst", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_done", 32'(done0), 32'd0);
    chk("mid_rst_ovf1", 32'(ovf1),  32'd0);
    chk("mid_rst_an",   32'(an0),   32'b1110);
    chk("mid_rst_seg",  32'(seg0),  32'(S0));
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    bn = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done0) dn++;
      if (busy0) bn++;
    end
    chk("post_rst_no_done", 32'(dn), 32'd0);
    chk("post_rst_no_busy", 32'(bn), 32'd0);
    check_digit(0, 0, S0, "post_rst_u0_d0");
    check_digit(0, 1, BL, "post_rst_u0_d1");
    check_digit(1, 0, S0, "post_rst_u1_d0");

    // Full sweep against the decimal reference model
    for (int v = 0; v < 512; v++) begin
      convert(9'(v), 0, 9'd0, bn, dn, da);
      chk($sformatf("sw_done_v%0d", v), 32'(dn), 32'd1);
      chk($sformatf("sw_ovf0_v%0d", v), 32'(ovf0), 32'(model_ovf(4, 1'b0, v)));
      chk($sformatf("sw_ovf1_v%0d", v), 32'(ovf1), 32'(model_ovf(2, 1'b0, v)));
      chk($sformatf("sw_ovf2_v%0d", v), 32'(ovf2), 32'(model_ovf(4, 1'b1, v)));
      chk($sformatf("sw_ovf3_v%0d", v), 32'(ovf3), 32'(model_ovf(4, 1'b1, v)));
      for (int d = 0; d < 4; d++) begin
        bit seen;
        wait_an(0, d, seen);
        chk($sformatf("sw_seen_v%0d_d%0d", v, d), 32'(seen), 32'd1);
        chk($sformatf("sw_u0_v%0d_d%0d", v, d), 32'(cur_seg(0)), 32'(model_seg(4, 1'b0, 1'b1, v, d)));
        chk($sformatf("sw_u2_v%0d_d%0d", v, d), 32'(cur_seg(2)), 32'(model_seg(4, 1'b1, 1'b1, v, d)));
        chk($sformatf("sw_u3_v%0d_d%0d", v, d), 32'(cur_seg(3)), 32'(model_seg(4, 1'b1, 1'b0, v, d)));
      end
      for (int d = 0; d < 2; d++) begin
        bit seen;
        wait_an(1, d, seen);
        chk($sformatf("sw_seen1_v%0d_d%0d", v, d), 32'(seen), 32'd1);
        chk($sformatf("sw_u1_v%0d_d%0d", v, d), 32'(cur_seg(1)), 32'(model_seg(2, 1'b0, 1'b1, v, d)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
